// File: rtl/mod_mul_pkg.sv
// Shared ALU definitions for the modular multiplier.
package mod_mul_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReduce,
        StMul
    } state_t;

    typedef logic [4:0] cnt_t;

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtract: returns t >= p ? t - p : t.
module mod_cond_sub
    import mod_mul_pkg::*;
(
    input  logic [WIDTH+1:0] t_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH+1:0] r_o
);

    logic [WIDTH+1:0] p_ext;

    // Zero-extend the modulus and subtract it when it fits.
    always_comb begin
        p_ext = {2'b00, p_i};
        if (t_i >= p_ext) begin
            r_o = t_i - p_ext;
        end else begin
            r_o = t_i;
        end
    end

endmodule

// File: rtl/mod_mul.sv
// Sequential modular multiplier: outC = (a * b) mod p, one bit per cycle.
// b is first reduced mod p (32 cycles), then MSB-first interleaved
// multiply-reduce over a (32 cycles).
module mod_mul
    import mod_mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] outC,
    output logic             rdy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    // Running remainder in REDUCE, running product R in MUL; always < p.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic [WIDTH-1:0] outc_q, outc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH+1:0] red_t;
    logic [WIDTH+1:0] mul_t;
    logic [WIDTH+1:0] sub1_in;
    logic [WIDTH+1:0] sub1_out;
    logic [WIDTH+1:0] sub2_out;
    logic             unused_sub_msbs;

    // Candidate values for both phases; the first subtractor is shared via a mux.
    always_comb begin
        red_t   = {1'b0, acc_q, b_q[cnt_q]};
        mul_t   = {1'b0, acc_q, 1'b0} + (a_q[cnt_q] ? {2'b00, br_q} : '0);
        sub1_in = (state_q == StMul) ? mul_t : red_t;
    end

    mod_cond_sub u_sub1 (
        .t_i (sub1_in),
        .p_i (p_q),
        .r_o (sub1_out)
    );

    mod_cond_sub u_sub2 (
        .t_i (sub1_out),
        .p_i (p_q),
        .r_o (sub2_out)
    );

    // Both reductions leave results below p, so the top two bits are always zero.
    assign unused_sub_msbs = ^sub2_out[WIDTH+1:WIDTH];

    // Next-state logic: FSM, counter and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        acc_d   = acc_q;
        br_d    = br_q;
        outc_d  = outc_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    p_d     = p;
                    err_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = 5'd31;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (p_q == '0) begin
                    // Modulus zero: finish immediately with an error.
                    outc_d  = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    br_d    = sub1_out[WIDTH-1:0];
                    acc_d   = '0;
                    cnt_d   = 5'd31;
                    state_d = StMul;
                end else begin
                    acc_d = sub1_out[WIDTH-1:0];
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StMul: begin
                acc_d = sub2_out[WIDTH-1:0];
                if (cnt_q == 5'd0) begin
                    outc_d  = sub2_out[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            br_q    <= '0;
            outc_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            outc_q  <= outc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Registered outputs; rdy is a straight decode of the idle state.
    always_comb begin
        outC = outc_q;
        done = done_q;
        err  = err_q;
        rdy  = (state_q == StIdle);
    end

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul against a 64-bit arithmetic reference.
module tb_mod_mul;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] outC;
    logic        rdy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    mod_mul dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .p       (p),
        .outC    (outC),
        .rdy     (rdy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] m);
        logic [63:0] prod;
        if (m == 32'd0) return 32'd0;
        prod = 64'(x) * 64'(y);
        return 32'(prod % 64'(m));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] m);
        a     = x;
        b     = y;
        p     = m;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        p     = $urandom;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, lat);
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] m);
        int          lat;
        logic [31:0] exp_c;
        int          exp_lat;
        exp_c   = ref_mul(x, y, m);
        exp_lat = (m == 32'd0) ? 1 : 64;
        launch(x, y, m);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy_after_accept: got %b, required 0", name, rdy);
        end
        wait_done(name, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (outC !== exp_c) begin
            errors++;
            $display("FAIL %s outC: got %h, required %h (a=%h b=%h p=%h)",
                     name, outC, exp_c, x, y, m);
        end
        checks++;
        if (err !== (m == 32'd0)) begin
            errors++;
            $display("FAIL %s err: got %b, required %b", name, err, (m == 32'd0));
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s rdy_at_done: got %b, required 1", name, rdy);
        end
        step();
        checks++;
        if (done !== 1'b0 || outC !== exp_c) begin
            errors++;
            $display("FAIL %s done_pulse/hold: done=%b outC=%h, required 0/%h",
                     name, done, outC, exp_c);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        p       = '0;
        #1;
        checks++;
        if ({rdy, done, err, outC} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b done=%b err=%b outC=%h, required 1/0/0/0",
                     rdy, done, err, outC);
        end
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({rdy, done, err, outC} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b done=%b err=%b outC=%h, required 1/0/0/0",
                     rdy, done, err, outC);
        end
    endtask

    task automatic test_directed();
        check_op("inverse_3x5_mod7", 32'd3, 32'd5, 32'd7);
        check_op("b_ge_p", 32'd2, 32'd100, 32'd7);
        check_op("wide_operands", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        check_op("p_one", 32'hDEAD_BEEF, 32'h1234_5678, 32'd1);
        check_op("p_zero", 32'd5, 32'd9, 32'd0);
        check_op("after_error", 32'd1, 32'd1, 32'd3);
    endtask

    task automatic test_random();
        logic [31:0] x, y, m;
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            unique case (i % 4)
                0: m = $urandom_range(1, 255);
                1: m = $urandom | 32'h8000_0000;
                2: m = $urandom;
                default: m = 32'hFFFF_FFFF - $urandom_range(0, 15);
            endcase
            check_op("random", x, y, m);
        end
    endtask

    task automatic test_ignore_start();
        int          lat;
        logic [31:0] exp_c;
        exp_c = ref_mul(32'h0001_2345, 32'h0ABC_DEF0, 32'h7FFF_FFFF);
        launch(32'h0001_2345, 32'h0ABC_DEF0, 32'h7FFF_FFFF);
        repeat (9) step();
        a     = 32'd7;
        b     = 32'd11;
        p     = 32'd13;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignore_start", lat);
        checks++;
        if (lat + 10 != 64) begin
            errors++;
            $display("FAIL ignore_start latency: got %0d, required 64", lat + 10);
        end
        checks++;
        if (outC !== exp_c) begin
            errors++;
            $display("FAIL ignore_start outC: got %h, required %h", outC, exp_c);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] exp1, exp2;
        exp1 = ref_mul(32'd123456, 32'd654321, 32'd1000003);
        exp2 = ref_mul(32'hCAFE_F00D, 32'h0BAD_CAFE, 32'hFFF0_0001);
        launch(32'd123456, 32'd654321, 32'd1000003);
        wait_done("b2b_first", lat);
        checks++;
        if (outC !== exp1 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first outC/rdy: got %h/%b, required %h/1", outC, rdy, exp1);
        end
        // Start in the done cycle must be accepted.
        launch(32'hCAFE_F00D, 32'h0BAD_CAFE, 32'hFFF0_0001);
        checks++;
        if (rdy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept rdy/done: got %b/%b, required 0/0", rdy, done);
        end
        repeat (30) step();
        checks++;
        if (outC !== exp1) begin
            errors++;
            $display("FAIL b2b_hold outC: got %h, required %h", outC, exp1);
        end
        wait_done("b2b_second", lat);
        checks++;
        if (lat + 30 != 64 || outC !== exp2) begin
            errors++;
            $display("FAIL b2b_second latency/outC: got %0d/%h, required 64/%h",
                     lat + 30, outC, exp2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        check_op("pre_abort", 32'd3, 32'd5, 32'd7);
        launch(32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_FFF1);
        repeat (29) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rdy, done, err, outC} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL abort_values: rdy=%b done=%b err=%b outC=%h, required 1/0/0/0",
                     rdy, done, err, outC);
        end
        repeat (2) step();
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || outC !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_done: pulses=%0d outC=%h, required 0/0", pulses, outC);
        end
        check_op("after_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_mul.md
# mod_mul

Sequential 32-bit modular multiplier computing outC = (a · b) mod p with a start/rdy handshake. It is the counterpart to the binary extended-Euclid inverse unit in the ALU. The inverse unit produces k⁻¹ mod p; this block consumes such values, so (k · k⁻¹) mod p = 1 closes the loop. The datapath reduces b modulo p by restoring shift-subtract, then runs MSB-first interleaved multiply-reduce, one bit per cycle.

## Interface
- WIDTH, 32, operand/result width; the only supported value is 32.
- clk  in  1  clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while rdy=1.
- a  in  32  multiplier, unsigned, any value.
- b  in  32  multiplicand, unsigned, any value (reduced internally).
- p  in  32  modulus, unsigned; p=0 is an error.
- outC  out  32  result, unsigned, always < p; held until the next completion.
- rdy  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse on the cycle a result (or error) becomes valid.
- err  out  1  high if the last accepted operation had p=0; cleared on the next accept.

## Operation
- States:
  - IDLE: rdy=1.
  - REDUCE: 32 cycles.
  - MUL: 32 cycles.
- Accept (IDLE, start=1):
  - latch a, b, p; clear err; rdy drops next cycle.
  - set rem=0 and cnt=31.
  - if p=0, go straight to finish-with-error.
- REDUCE step i (cnt=31..0):
  - rem ← (rem<<1)|b[cnt]; if rem ≥ p then rem ← rem−p.
  - rem is 33-bit.
  - after cnt=0, bR=rem (< p); R=0; cnt=31; go to MUL.
- MUL step (cnt=31..0):
  - T = 2R + (a[cnt] ? bR : 0), 34-bit, T < 3p.
  - T ← T−p if T ≥ p, then again T ← T−p if T ≥ p.
  - R ← T.
  - after cnt=0: outC ← R[31:0], done=1 for one cycle, go to IDLE.
- Error finish: outC ← 0, err ← 1, done=1, IDLE.
- p=1 yields outC=0 through the normal path with no special case.
- start while rdy=0 is ignored with no queueing. Inputs a/b/p are don't-care after the accept edge.

## Timing
- Reset values: rdy=1, done=0, err=0, outC=0; state=IDLE; internal registers 0.
- Accept edge E0: rdy=0 after E0.
- E1–E32: REDUCE.
- E33–E64: MUL.
- After E64: outC valid, rdy=1, done=1 for exactly one cycle.
- Latency is 64 cycles from the accept edge to valid result.
- p=0: result after E1 (latency 1), with err=1 and done=1.
- Back-to-back operation: start may be asserted in the same cycle done=1. That start is accepted (rdy=1) and begins a new operation. outC/err hold their values until that operation finishes.
- Reset asserted mid-operation: immediate abort to reset values; no done pulse.

## Structure
- Shared ALU package: WIDTH=32 constant; state enum {IDLE, REDUCE, MUL}; 5-bit counter type.
- One sub-module, mod_cond_sub: combinational, 34-bit T and 32-bit p in, returns T ≥ p ? T−p : T.
  - Instantiated once in REDUCE and twice in series in MUL.
  - The instance may be shared across states through a mux.
- FSM, counter and datapath live in mod_mul.

## Test plan
- a=3, b=5, p=7 (inverse-unit check: 5 = 3⁻¹ mod 7) → outC=1, done after 64 cycles, err=0.
- a=2, b=100, p=7 (b ≥ p) → outC=4.
- a=0xFFFFFFFF, b=0xFFFFFFFF, p=0xFFFFFFFB → outC=16; tests the 34-bit datapath with no overflow.
- p=0, a=5, b=9 → after 1 cycle outC=0, err=1, one done pulse; next op a=1, b=1, p=3 → err cleared, outC=1.
- start re-pulsed at cycle 10 with different operands → ignored, first result is unchanged; a start in the done cycle is accepted.
- reset_n low at cycle 30 of an operation → rdy=1, outC=0, done never pulses; a fresh op afterwards is correct.
